// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and memory.
// Latency: none; this is plain wiring.
// Backpressure: imem_req is held with a stable address until imem_ack arrives.
//
// Signals:
//   imem_req   - fetch unit requests the word at imem_addr
//   imem_addr  - request word address
//   imem_ack   - memory returns data; a transfer is imem_req & imem_ack at an edge
//   imem_rdata - instruction word, valid when imem_ack is 1
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: fetches one word and holds it in PC/IM until the F/D register takes it.
// Latency: the word is held the edge after the transfer; a zero-wait ack gives one instruction every two cycles.
// Backpressure: en=0 holds PC/IM/valid; imem_addr stays stable until the memory acks.
//
// Ports:
//   clk, reset                  - single clock; asynchronous active-low reset
//   en                          - downstream accepts the held instruction this edge
//   br_taken, br_target         - redirect that takes effect after the current delay-slot instruction
//   flush                       - discard held and in-flight work and restart at FLUSH_PC
//   imem                        - instruction memory bus (master side)
//   PC, IM, valid, fetch_err    - held instruction address, word, valid flag and misalignment flag
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h00003000,
    parameter logic [31:0] FLUSH_PC = 32'h00004180
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               br_taken,
    input  logic [31:0]        br_target,
    input  logic               flush,
    fetch_unit_if.master       imem,
    output logic [31:0]        PC,
    output logic [31:0]        IM,
    output logic               valid,
    output logic               fetch_err
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DROP  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] im_q, im_d;
    logic        valid_q, valid_d;
    logic        ferr_q, ferr_d;
    logic        pend_vld_q, pend_vld_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    // While dropping, PC already points at FLUSH_PC but the bus must keep
    // presenting the abandoned address until its ack arrives.
    logic [31:0] drop_addr_q, drop_addr_d;

    logic misalign;
    logic req;
    logic xfer;

    assign misalign = (pc_q[1:0] != 2'b00);
    // A misaligned PC never reaches memory; it is turned into an error slot instead.
    assign req      = (state_q == S_DROP) || ((state_q == S_FETCH) && !misalign);
    assign xfer     = req && imem.imem_ack;

    assign imem.imem_req  = req;
    assign imem.imem_addr = (state_q == S_DROP) ? drop_addr_q : pc_q;

    assign PC        = pc_q;
    assign IM        = im_q;
    assign valid     = valid_q;
    assign fetch_err = ferr_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            im_q        <= '0;
            valid_q     <= 1'b0;
            ferr_q      <= 1'b0;
            pend_vld_q  <= 1'b0;
            pend_pc_q   <= '0;
            drop_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            im_q        <= im_d;
            valid_q     <= valid_d;
            ferr_q      <= ferr_d;
            pend_vld_q  <= pend_vld_d;
            pend_pc_q   <= pend_pc_d;
            drop_addr_q <= drop_addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        im_d        = im_q;
        valid_d     = valid_q;
        ferr_d      = ferr_q;
        pend_vld_d  = pend_vld_q;
        pend_pc_d   = pend_pc_q;
        drop_addr_d = drop_addr_q;

        // A branch that is not consumed this edge is parked; the newest one wins.
        // The consume and flush paths below override this.
        if (br_taken) begin
            pend_vld_d = 1'b1;
            pend_pc_d  = br_target;
        end

        case (state_q)
            S_FETCH: begin
                if (flush) begin
                    pc_d       = FLUSH_PC;
                    valid_d    = 1'b0;
                    ferr_d     = 1'b0;
                    pend_vld_d = 1'b0;
                    // An outstanding request cannot be withdrawn; swallow its data later.
                    if (req && !xfer) begin
                        state_d     = S_DROP;
                        drop_addr_d = pc_q;
                    end
                end else if (misalign) begin
                    state_d = S_HOLD;
                    im_d    = '0;
                    valid_d = 1'b1;
                    ferr_d  = 1'b1;
                end else if (xfer) begin
                    state_d = S_HOLD;
                    im_d    = imem.imem_rdata;
                    valid_d = 1'b1;
                    ferr_d  = 1'b0;
                end
            end
            S_HOLD: begin
                if (flush) begin
                    state_d    = S_FETCH;
                    pc_d       = FLUSH_PC;
                    valid_d    = 1'b0;
                    ferr_d     = 1'b0;
                    pend_vld_d = 1'b0;
                end else if (en) begin
                    state_d    = S_FETCH;
                    valid_d    = 1'b0;
                    ferr_d     = 1'b0;
                    pend_vld_d = 1'b0;
                    if (pend_vld_q) begin
                        pc_d = pend_pc_q;
                    end else if (br_taken) begin
                        pc_d = br_target;
                    end else begin
                        pc_d = pc_q + 32'd4;
                    end
                end
            end
            S_DROP: begin
                if (flush) begin
                    pc_d       = FLUSH_PC;
                    pend_vld_d = 1'b0;
                end
                // Data of the abandoned request is thrown away.
                if (xfer) begin
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        en;
    logic        br_taken;
    logic [31:0] br_target;
    logic        flush;
    logic [31:0] PC;
    logic [31:0] IM;
    logic        valid;
    logic        fetch_err;

    logic        ack;
    logic        force_en;
    logic [31:0] force_dat;

    int n_chk  = 0;
    int n_fail = 0;

    fetch_unit_if bus ();

    // Memory model: word at address A reads as A ^ 32'hC0DE0000 unless overridden.
    assign bus.imem_ack   = ack;
    assign bus.imem_rdata = force_en ? force_dat : (bus.imem_addr ^ 32'hC0DE0000);

    fetch_unit dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .br_taken  (br_taken),
        .br_target (br_target),
        .flush     (flush),
        .imem      (bus),
        .PC        (PC),
        .IM        (IM),
        .valid     (valid),
        .fetch_err (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        en        = 1'b0;
        br_taken  = 1'b0;
        br_target = '0;
        flush     = 1'b0;
        ack       = 1'b0;
        force_en  = 1'b0;
        force_dat = '0;
        step();
        step();
        reset = 1'b1;
    endtask

    initial begin
        // ---------------- reset state ----------------
        do_reset();
        reset = 1'b0;
        #1;
        chk("rst_pc",    PC,        32'h00003000);
        chk("rst_im",    IM,        32'h0);
        chk("rst_valid", {31'b0, valid},     32'd0);
        chk("rst_ferr",  {31'b0, fetch_err}, 32'd0);
        reset = 1'b1;

        // ---------------- streaming, zero-wait ack ----------------
        ack = 1'b1;
        en  = 1'b1;
        chk("t0_req",   {31'b0, bus.imem_req}, 32'd1);
        chk("t0_addr",  bus.imem_addr, 32'h00003000);
        step();
        chk("t1_valid", {31'b0, valid}, 32'd1);
        chk("t1_pc",    PC, 32'h00003000);
        chk("t1_im",    IM, 32'hC0DE3000);
        step();
        chk("t2_valid", {31'b0, valid}, 32'd0);
        chk("t2_addr",  bus.imem_addr, 32'h00003004);
        step();
        chk("t3_valid", {31'b0, valid}, 32'd1);
        chk("t3_pc",    PC, 32'h00003004);
        chk("t3_im",    IM, 32'hC0DE3004);
        step();
        chk("t4_valid", {31'b0, valid}, 32'd0);
        step();
        chk("t5_pc",    PC, 32'h00003008);
        chk("t5_im",    IM, 32'hC0DE3008);

        // ---------------- branch while held, en low two cycles ----------------
        en        = 1'b0;
        br_taken  = 1'b1;
        br_target = 32'h00003100;
        step();
        br_taken  = 1'b0;
        br_target = 32'h0;
        chk("br_hold1_valid", {31'b0, valid}, 32'd1);
        chk("br_hold1_pc",    PC, 32'h00003008);
        step();
        chk("br_hold2_pc",    PC, 32'h00003008);
        chk("br_hold2_im",    IM, 32'hC0DE3008);
        en = 1'b1;
        step();
        chk("br_addr",  bus.imem_addr, 32'h00003100);
        chk("br_req",   {31'b0, bus.imem_req}, 32'd1);
        step();
        chk("br_im",    IM, 32'hC0DE3100);
        step();
        chk("br_next",  bus.imem_addr, 32'h00003104);

        // ---------------- delayed ack at 0x3004 ----------------
        do_reset();
        ack = 1'b1;
        en  = 1'b1;
        step();
        chk("dly_t1_pc", PC, 32'h00003000);
        ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("dly_addr%0d", i),  bus.imem_addr, 32'h00003004);
            chk($sformatf("dly_valid%0d", i), {31'b0, valid}, 32'd0);
        end
        ack = 1'b1;
        step();
        chk("dly_valid", {31'b0, valid}, 32'd1);
        chk("dly_im",    IM, 32'hC0DE3004);

        // ---------------- flush with outstanding request at 0x300C ----------------
        step();
        step();
        chk("fl_pre_pc", PC, 32'h00003008);
        ack = 1'b0;
        step();
        chk("fl_addr0", bus.imem_addr, 32'h0000300C);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_drop_addr",  bus.imem_addr, 32'h0000300C);
        chk("fl_drop_req",   {31'b0, bus.imem_req}, 32'd1);
        chk("fl_drop_valid", {31'b0, valid}, 32'd0);
        chk("fl_drop_pc",    PC, 32'h00004180);
        step();
        chk("fl_drop2_addr", bus.imem_addr, 32'h0000300C);
        force_en  = 1'b1;
        force_dat = 32'hDEADBEEF;
        ack       = 1'b1;
        step();
        force_en = 1'b0;
        chk("fl_after_valid", {31'b0, valid}, 32'd0);
        chk("fl_after_im",    IM, 32'hC0DE3008);
        chk("fl_after_addr",  bus.imem_addr, 32'h00004180);
        step();
        chk("fl_hold_im",     IM, 32'hC0DE4180);

        // ---------------- misaligned branch target ----------------
        br_taken  = 1'b1;
        br_target = 32'h00003102;
        step();
        br_taken = 1'b0;
        en       = 1'b0;
        chk("mis_req0",   {31'b0, bus.imem_req}, 32'd0);
        chk("mis_valid0", {31'b0, valid}, 32'd0);
        step();
        chk("mis_valid", {31'b0, valid}, 32'd1);
        chk("mis_pc",    PC, 32'h00003102);
        chk("mis_im",    IM, 32'h0);
        chk("mis_ferr",  {31'b0, fetch_err}, 32'd1);
        chk("mis_req",   {31'b0, bus.imem_req}, 32'd0);
        en = 1'b1;
        step();
        chk("mis_next_ferr", {31'b0, fetch_err}, 32'd0);
        chk("mis_next_pc",   PC, 32'h00003106);
        en = 1'b0;
        step();

        // ---------------- PC wrap-around ----------------
        en        = 1'b1;
        br_taken  = 1'b1;
        br_target = 32'hFFFFFFFC;
        step();
        br_taken = 1'b0;
        chk("wrap_addr0", bus.imem_addr, 32'hFFFFFFFC);
        step();
        chk("wrap_im",    IM, 32'h3F21FFFC);
        step();
        chk("wrap_addr",  bus.imem_addr, 32'h00000000);

        // ---------------- flush beats branch and en in HOLD ----------------
        step();
        chk("prio_pc0",  PC, 32'h00000000);
        flush     = 1'b1;
        br_taken  = 1'b1;
        br_target = 32'h00005000;
        step();
        flush    = 1'b0;
        br_taken = 1'b0;
        chk("prio_addr",  bus.imem_addr, 32'h00004180);
        chk("prio_valid", {31'b0, valid}, 32'd0);
        step();
        step();
        chk("prio_next",  bus.imem_addr, 32'h00004184);

        // ---------------- reset mid-fetch ignores late ack ----------------
        ack = 1'b0;
        step();
        reset = 1'b0;
        ack   = 1'b1;
        #1;
        chk("rmid_pc",    PC, 32'h00003000);
        chk("rmid_valid", {31'b0, valid}, 32'd0);
        step();
        chk("rmid_valid2", {31'b0, valid}, 32'd0);
        chk("rmid_im",     IM, 32'h0);
        reset = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
